onehot_monitor: RTL

Synthesizable, parametrised multi-channel monitor for one-hot and one-hot-or-zero properties, with an antecedent per channel. It is the hardware equivalent of the assertion "ante |-> ##DELAY $onehot(vec)", generalised in width, channel count, check mode and implication delay. It adds counters, sticky error flags and first-failure capture. It sits beside a datapath or FSM and drives status/debug registers; it never alters the monitored signals.

---
 rtl/onehot_monitor_pkg.sv | 40 ++++
 rtl/onehot_monitor_if.sv | 45 ++++
 rtl/onehot_chk_lane.sv | 80 ++++++++
 rtl/onehot_monitor.sv | 131 +++++++++++++
 4 files changed

// File: rtl/onehot_monitor_pkg.sv
// rtl/onehot_monitor_pkg.sv - shared types and helpers for the one-hot monitor
//
// Purpose: check-mode enum, implication-delay limit, popcount and
//          saturating-add helpers used by the lanes and the top level.
// Ports:   none (package).
package onehot_mon_pkg;

  // Deepest implication delay a lane is built for.
  localparam int DELAY_MAX = 3;

  // Widest vector the popcount helper accepts; callers zero-extend into it.
  localparam int POP_W  = 256;
  localparam int POPC_W = 9;

  typedef enum logic {
    MODE_ONEHOT  = 1'b0,
    MODE_ONEHOT0 = 1'b1
  } chk_mode_e;

  function automatic logic [POPC_W-1:0] popcount(input logic [POP_W-1:0] v);
    logic [POPC_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + POPC_W'(v[i]);
    end
    return n;
  endfunction

  // a + b clamped to 2^w - 1; the extra sum bit keeps the clamp exact at w = 64.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int          w);
    logic [63:0] max_v;
    logic [64:0] sum;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum   = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[63:0];
  endfunction

endpackage

// File: rtl/onehot_monitor_if.sv
// rtl/onehot_monitor_if.sv - monitored-signal and status bundle for onehot_monitor
//
// Purpose: groups the attempt inputs and the status/debug outputs.
// Signals: clr, enable, ante[NCH], vec[NCH*WIDTH], mode[NCH]   (master -> slave)
//          pass_pulse, fail_pulse, err_sticky[NCH], pass_cnt, fail_cnt,
//          first_vld, first_ch, first_vec, first_time          (slave -> master)
// Modports: master = datapath side driving the observed signals,
//           slave  = the monitor.
interface onehot_monitor_if #(
  parameter int WIDTH = 2,
  parameter int NCH   = 1,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                   clr;
  logic                   enable;
  logic [NCH-1:0]         ante;
  logic [NCH*WIDTH-1:0]   vec;
  logic [NCH-1:0]         mode;

  logic [NCH-1:0]         pass_pulse;
  logic [NCH-1:0]         fail_pulse;
  logic [NCH-1:0]         err_sticky;
  logic [CNT_W-1:0]       pass_cnt;
  logic [CNT_W-1:0]       fail_cnt;
  logic                   first_vld;
  logic [CH_W-1:0]        first_ch;
  logic [WIDTH-1:0]       first_vec;
  logic [TS_W-1:0]        first_time;

  modport master (
    output clr, enable, ante, vec, mode,
    input  pass_pulse, fail_pulse, err_sticky, pass_cnt, fail_cnt,
           first_vld, first_ch, first_vec, first_time
  );

  modport slave (
    input  clr, enable, ante, vec, mode,
    output pass_pulse, fail_pulse, err_sticky, pass_cnt, fail_cnt,
           first_vld, first_ch, first_vec, first_time
  );

endinterface

// File: rtl/onehot_chk_lane.sv
// rtl/onehot_chk_lane.sv - one channel of the one-hot monitor
//
// Purpose: delays the launch bit by DELAY cycles, then checks vec against
//          the channel's mode at the evaluation edge.
// Ports:   clk, rst_n        clock, asynchronous active-low reset
//          clr               discards in-flight attempts and the current result
//          launch            enable & ante for this channel
//          vec, mode         vector and check mode sampled at evaluation
//          eval_pass/fail    unregistered result of the attempt due this edge
//          pass/fail_pulse   registered one-cycle result pulses
module onehot_chk_lane
  import onehot_mon_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DELAY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             launch,
  input  logic [WIDTH-1:0] vec,
  input  logic             mode,
  output logic             eval_pass,
  output logic             eval_fail,
  output logic             pass_pulse,
  output logic             fail_pulse
);

  logic              due;
  logic [POP_W-1:0]  vec_ext;
  logic [POPC_W-1:0] ones;
  logic              ok;

  generate
    if (DELAY == 0) begin : g_overlap
      assign due = launch;
    end else begin : g_delay
      // One bit per cycle of flight, so a new attempt can start every cycle.
      logic [DELAY-1:0] launch_sr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          launch_sr <= '0;
        end else if (clr) begin
          launch_sr <= '0;
        end else begin
          launch_sr <= (launch_sr << 1) | DELAY'(launch);
        end
      end

      assign due = launch_sr[DELAY-1];
    end
  endgenerate

  always_comb begin
    vec_ext            = '0;
    vec_ext[WIDTH-1:0] = vec;
  end

  assign ones = popcount(vec_ext);
  assign ok   = (chk_mode_e'(mode) == MODE_ONEHOT0) ? (ones <= POPC_W'(1))
                                                    : (ones == POPC_W'(1));

  assign eval_pass = due & ok;
  assign eval_fail = due & ~ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
    end else if (clr) begin
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      pass_pulse <= eval_pass;
      fail_pulse <= eval_fail;
    end
  end

endmodule

// File: rtl/onehot_monitor.sv
// rtl/onehot_monitor.sv - multi-channel one-hot / one-hot-or-zero implication monitor
//
// Purpose: hardware form of "ante |-> ##DELAY $onehot(vec)" per channel, with
//          saturating pass/fail totals, sticky error flags and capture of the
//          first failure (channel, vector, timestamp).
// Ports:   clk      sampling clock (posedge)
//          rst_n    asynchronous active-low reset
//          mon      onehot_monitor_if.slave: clr, enable, ante, vec, mode in;
//                   pass_pulse, fail_pulse, err_sticky, pass_cnt, fail_cnt,
//                   first_vld, first_ch, first_vec, first_time out
module onehot_monitor
  import onehot_mon_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int NCH   = 1,
  parameter int DELAY = 0,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input logic              clk,
  input logic              rst_n,
  onehot_monitor_if.slave  mon
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   ev_pass;
  logic [NCH-1:0]   ev_fail;
  logic [NCH-1:0]   pass_q;
  logic [NCH-1:0]   fail_q;
  logic [NCH-1:0]   err_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CNT_W-1:0] pass_cnt_nx;
  logic [CNT_W-1:0] fail_cnt_nx;
  logic [TS_W-1:0]  ts_q;
  logic             first_vld_q;
  logic [CH_W-1:0]  first_ch_q;
  logic [WIDTH-1:0] first_vec_q;
  logic [TS_W-1:0]  first_time_q;
  logic [CH_W-1:0]  fail_idx;
  logic [WIDTH-1:0] fail_vec;
  logic [POP_W-1:0] pass_ext;
  logic [POP_W-1:0] fail_ext;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    onehot_chk_lane #(
      .WIDTH (WIDTH),
      .DELAY (DELAY)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (mon.clr),
      .launch     (mon.enable & mon.ante[g]),
      .vec        (mon.vec[g*WIDTH +: WIDTH]),
      .mode       (mon.mode[g]),
      .eval_pass  (ev_pass[g]),
      .eval_fail  (ev_fail[g]),
      .pass_pulse (pass_q[g]),
      .fail_pulse (fail_q[g])
    );
  end

  always_comb begin
    pass_ext          = '0;
    fail_ext          = '0;
    pass_ext[NCH-1:0] = ev_pass;
    fail_ext[NCH-1:0] = ev_fail;
  end

  assign pass_cnt_nx = CNT_W'(sat_add(64'(pass_cnt_q), 64'(popcount(pass_ext)), CNT_W));
  assign fail_cnt_nx = CNT_W'(sat_add(64'(fail_cnt_q), 64'(popcount(fail_ext)), CNT_W));

  // Scan from the top down so the lowest failing channel is the last writer.
  always_comb begin
    fail_idx = '0;
    fail_vec = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ev_fail[i]) begin
        fail_idx = CH_W'(i);
        fail_vec = mon.vec[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      err_q        <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      first_vld_q  <= 1'b0;
      first_ch_q   <= '0;
      first_vec_q  <= '0;
      first_time_q <= '0;
    end else begin
      // The timestamp keeps running through clr so captures stay comparable.
      ts_q <= ts_q + TS_W'(1);
      if (mon.clr) begin
        err_q        <= '0;
        pass_cnt_q   <= '0;
        fail_cnt_q   <= '0;
        first_vld_q  <= 1'b0;
        first_ch_q   <= '0;
        first_vec_q  <= '0;
        first_time_q <= '0;
      end else begin
        err_q      <= err_q | ev_fail;
        pass_cnt_q <= pass_cnt_nx;
        fail_cnt_q <= fail_cnt_nx;
        if (!first_vld_q && (|ev_fail)) begin
          first_vld_q  <= 1'b1;
          first_ch_q   <= fail_idx;
          first_vec_q  <= fail_vec;
          first_time_q <= ts_q;
        end
      end
    end
  end

  assign mon.pass_pulse = pass_q;
  assign mon.fail_pulse = fail_q;
  assign mon.err_sticky = err_q;
  assign mon.pass_cnt   = pass_cnt_q;
  assign mon.fail_cnt   = fail_cnt_q;
  assign mon.first_vld  = first_vld_q;
  assign mon.first_ch   = first_ch_q;
  assign mon.first_vec  = first_vec_q;
  assign mon.first_time = first_time_q;

endmodule
